// File: rtl/rc5_pkg.sv
// rc5_pkg: shared widths, operation and state encodings, and the job record
// used by the RC5 core request scheduler.
package rc5_pkg;
    localparam int RC5_WORD_W   = 32;
    localparam int RC5_KEY_W    = 128;
    localparam int RC5_ROUNDS_W = 5;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } rc5_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    typedef struct packed {
        rc5_op_e                  op;
        logic [RC5_ROUNDS_W-1:0]  rounds;
        logic [RC5_KEY_W-1:0]     key;
        logic [RC5_WORD_W-1:0]    data;
    } rc5_job_t;
endpackage

// File: rtl/rc5_core_sched_if.sv
// rc5_core_sched_if: requester-side job and response handshakes.
//   req_valid/req_ready  per-requester job handshake
//   req_op/rounds/key/data  job fields, one lane per requester
//   rsp_valid/rsp_ready  per-requester result handshake
//   rsp_data/rsp_err     shared result word and error flag
// master = requester side, slave = scheduler side.
interface rc5_core_sched_if #(
    parameter int N_REQ = 2
);
    import rc5_pkg::*;

    logic [N_REQ-1:0]                         req_valid;
    logic [N_REQ-1:0]                         req_ready;
    logic [N_REQ-1:0]                         req_op;
    logic [N_REQ-1:0][RC5_ROUNDS_W-1:0]       req_rounds;
    logic [N_REQ-1:0][RC5_KEY_W-1:0]          req_key;
    logic [N_REQ-1:0][RC5_WORD_W-1:0]         req_data;
    logic [N_REQ-1:0]                         rsp_valid;
    logic [N_REQ-1:0]                         rsp_ready;
    logic [RC5_WORD_W-1:0]                    rsp_data;
    logic                                     rsp_err;

    modport master (
        output req_valid, req_op, req_rounds, req_key, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_rounds, req_key, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req    request vector
//   ptr    highest-priority index this cycle
//   grant  one-hot grant (all zero when no request)
//   idx    index of the granted requester (0 when none)
// Searches from ptr upward, wrapping, and grants the first request found.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);
    logic             found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sel = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end
endmodule

// File: rtl/rc5_core_sched.sv
// rc5_core_sched: grants the single RC5 core to one requester job at a time.
//   clk, rst         clock; asynchronous active-low reset
//   bus              requester job/response handshakes (slave side)
//   core_encrypt/decrypt  one-cycle start strobes to the core
//   core_num_rounds, core_key, core_d_in  latched job operands
//   core_d_out, core_done  core result and completion pulse
// Flow: IDLE (arbitrate, accept) -> ISSUE (strobe) -> WAIT (watchdog)
//       -> RESP (hold result until the owner consumes it) -> IDLE.
module rc5_core_sched
    import rc5_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    rc5_core_sched_if.slave          bus,
    output logic                     core_encrypt,
    output logic                     core_decrypt,
    output logic [RC5_ROUNDS_W-1:0]  core_num_rounds,
    output logic [RC5_KEY_W-1:0]     core_key,
    output logic [RC5_WORD_W-1:0]    core_d_in,
    input  logic [RC5_WORD_W-1:0]    core_d_out,
    input  logic                     core_done
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_e           state, state_nxt;
    rc5_job_t               job;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       wd_cnt;
    logic [RC5_WORD_W-1:0]  rsp_data_q;
    logic                   rsp_err_q;

    logic [N_REQ-1:0]       grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [N_REQ-1:0]       req_ready_c;
    logic [N_REQ-1:0]       rsp_valid_c;
    logic                   accept;
    logic                   rsp_load;
    logic [RC5_WORD_W-1:0]  rsp_data_nxt;
    logic                   rsp_err_nxt;
    logic                   rsp_done;

    // Reset asserts asynchronously but releases on a clock edge, so every
    // flop below leaves reset in the same cycle.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        rsp_load     = 1'b0;
        rsp_data_nxt = '0;
        rsp_err_nxt  = 1'b0;
        rsp_done     = 1'b0;
        core_encrypt = 1'b0;
        core_decrypt = 1'b0;
        req_ready_c  = '0;
        case (state)
            IDLE: begin
                // Gated by the internal reset so nothing is offered while
                // the scheduler is still held in reset.
                if (rst_int_n) begin
                    req_ready_c = grant;
                    if (|grant) begin
                        accept = 1'b1;
                        if (bus.req_rounds[grant_idx] == '0) begin
                            rsp_load    = 1'b1;
                            rsp_err_nxt = 1'b1;
                            state_nxt   = RESP;
                        end else begin
                            state_nxt = ISSUE;
                        end
                    end
                end
            end
            ISSUE: begin
                core_encrypt = (job.op == ENC);
                core_decrypt = (job.op == DEC);
                state_nxt    = WAIT;
            end
            WAIT: begin
                // A done arriving on the last watchdog cycle still wins.
                if (core_done) begin
                    rsp_load     = 1'b1;
                    rsp_data_nxt = core_d_out;
                    state_nxt    = RESP;
                end else if (wd_cnt == CNT_W'(TIMEOUT)) begin
                    rsp_load    = 1'b1;
                    rsp_err_nxt = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[owner]) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            job        <= '0;
            owner      <= '0;
            rr_ptr     <= '0;
            wd_cnt     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                job.op     <= rc5_op_e'(bus.req_op[grant_idx]);
                job.rounds <= bus.req_rounds[grant_idx];
                job.key    <= bus.req_key[grant_idx];
                job.data   <= bus.req_data[grant_idx];
                owner      <= grant_idx;
            end
            if (rsp_load) begin
                rsp_data_q <= rsp_data_nxt;
                rsp_err_q  <= rsp_err_nxt;
            end
            // Zero on entry to WAIT, so the first WAIT cycle sees 0.
            if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
            else               wd_cnt <= '0;
            if (rsp_done) begin
                rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

    always_comb begin
        rsp_valid_c = '0;
        if (state == RESP) rsp_valid_c[owner] = 1'b1;
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign core_num_rounds = job.rounds;
    assign core_key        = job.key;
    assign core_d_in       = job.data;
endmodule

// File: tb/tb_rc5_core_sched.sv
// tb_rc5_core_sched: directed scenarios for the RC5 core scheduler with a
// small behavioural core model (configurable latency, result, or hang).
module tb_rc5_core_sched;
    import rc5_pkg::*;

    localparam int N  = 2;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_encrypt, core_decrypt;
    logic [4:0]   core_num_rounds;
    logic [127:0] core_key;
    logic [31:0]  core_d_in;
    logic [31:0]  core_d_out = 32'h0;
    logic         core_done  = 1'b0;

    rc5_core_sched_if #(.N_REQ(N)) bus ();

    rc5_core_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .core_encrypt    (core_encrypt),
        .core_decrypt    (core_decrypt),
        .core_num_rounds (core_num_rounds),
        .core_key        (core_key),
        .core_d_in       (core_d_in),
        .core_d_out      (core_d_out),
        .core_done       (core_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // Core model: after a strobe, done pulses cm_delay cycles later.
    int          cm_delay  = 1;
    int          cm_cnt    = 0;
    logic        cm_hang   = 1'b0;
    logic [31:0] cm_result = 32'h0;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst) cm_cnt = 0;
        else if (cm_cnt > 0) begin
            cm_cnt--;
            if (cm_cnt == 0) begin
                core_done  = 1'b1;
                core_d_out = cm_result;
            end
        end else if ((core_encrypt || core_decrypt) && !cm_hang) begin
            cm_cnt = cm_delay;
        end
    end

    // Passive monitor: strobes, acceptances, handshakes, ready misuse.
    int   enc_cnt = 0, dec_cnt = 0, both_cnt = 0, viol = 0, hs_cnt = 0;
    int   acc_idx[$];
    int   acc_cyc[$];
    logic busy = 1'b0;

    always @(negedge clk) begin
        #2;
        if (!rst) busy = 1'b0;
        else begin
            if (core_encrypt) enc_cnt++;
            if (core_decrypt) dec_cnt++;
            if (core_encrypt && core_decrypt) both_cnt++;
            if ($countones(bus.req_ready) > 1) viol++;
            if (busy && (|bus.req_ready)) viol++;
            if (|(bus.rsp_valid & bus.rsp_ready)) begin
                busy = 1'b0;
                hs_cnt++;
            end
            if (|(bus.req_ready & bus.req_valid)) begin
                busy = 1'b1;
                acc_idx.push_back(bus.req_ready[1] ? 1 : 0);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic test_reset();
        rst           = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_rounds[0] = 5'd3;
        bus.req_rounds[1] = 5'd3;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); else passed++;
        checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); else passed++;
        checks++; if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); else passed++;
        checks++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); else passed++;
        checks++; if (core_encrypt !== 1'b0) $display("FAIL reset_encrypt got=%b exp=0", core_encrypt); else passed++;
        checks++; if (core_decrypt !== 1'b0) $display("FAIL reset_decrypt got=%b exp=0", core_decrypt); else passed++;
        checks++; if (core_num_rounds !== 5'd0) $display("FAIL reset_rounds got=%0d exp=0", core_num_rounds); else passed++;
        checks++; if (core_key !== 128'h0) $display("FAIL reset_key got=%h exp=0", core_key); else passed++;
        checks++; if (core_d_in !== 32'h0) $display("FAIL reset_d_in got=%h exp=0", core_d_in); else passed++;
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n0, h0, v0, e0, d0;
        int exp_idx[4] = '{0, 1, 0, 1};
        n0 = acc_idx.size(); h0 = hs_cnt; v0 = viol; e0 = enc_cnt; d0 = dec_cnt;
        cm_delay = 1; cm_hang = 1'b0; cm_result = 32'h0BAD_F00D;
        @(negedge clk);
        bus.rsp_ready     = 2'b11;
        bus.req_op        = 2'b10;
        bus.req_rounds[0] = 5'd8;
        bus.req_rounds[1] = 5'd8;
        bus.req_data[0]   = 32'hA0A0_0000;
        bus.req_data[1]   = 32'hB1B1_1111;
        bus.req_valid     = 2'b11;
        for (int i = 0; i < 60 && acc_idx.size() < n0 + 4; i++) @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (8) @(negedge clk);
        bus.rsp_ready = 2'b00;
        checks++;
        if (acc_idx.size() < n0 + 4) $display("FAIL rr_accepts got=%0d exp=4", acc_idx.size() - n0);
        else begin
            passed++;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_idx[n0 + k] != exp_idx[k]) $display("FAIL rr_grant%0d got=%0d exp=%0d", k, acc_idx[n0 + k], exp_idx[k]);
                else passed++;
            end
            checks++;
            if (acc_cyc[n0 + 3] - acc_cyc[n0] != 12) $display("FAIL rr_spacing got=%0d exp=12", acc_cyc[n0 + 3] - acc_cyc[n0]);
            else passed++;
        end
        checks++; if (hs_cnt - h0 != 4) $display("FAIL rr_responses got=%0d exp=4", hs_cnt - h0); else passed++;
        checks++; if (viol - v0 != 0) $display("FAIL rr_ready_outside_idle got=%0d exp=0", viol - v0); else passed++;
        checks++; if (enc_cnt - e0 != 2 || dec_cnt - d0 != 2) $display("FAIL rr_strobes got=%0d/%0d exp=2/2", enc_cnt - e0, dec_cnt - d0); else passed++;
    endtask

    task automatic test_single_encrypt();
        int t0, r, e0, d0;
        e0 = enc_cnt; d0 = dec_cnt;
        cm_delay = 13; cm_hang = 1'b0; cm_result = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.req_op[0] = 1'b0; bus.req_rounds[0] = 5'd12; bus.req_key[0] = '0; bus.req_data[0] = 32'h0;
        bus.req_valid[0] = 1'b1;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.req_ready[0]) begin t0 = cyc; break; end
            @(negedge clk);
        end
        checks++; if (t0 < 0) $display("FAIL enc_accept got=none exp=req0"); else passed++;
        @(negedge clk); #1;
        bus.req_valid[0] = 1'b0;
        checks++; if (core_encrypt !== 1'b1 || core_decrypt !== 1'b0) $display("FAIL enc_strobe got=%b%b exp=10", core_encrypt, core_decrypt); else passed++;
        checks++; if (core_num_rounds !== 5'd12) $display("FAIL enc_rounds got=%0d exp=12", core_num_rounds); else passed++;
        @(negedge clk); #1;
        checks++; if (core_encrypt !== 1'b0) $display("FAIL enc_strobe_width got=%b exp=0", core_encrypt); else passed++;
        r = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != 2'b00) begin r = cyc; break; end
        end
        checks++; if (r != t0 + 15) $display("FAIL enc_rsp_cycle got=%0d exp=%0d", r, t0 + 15); else passed++;
        checks++; if (bus.rsp_valid !== 2'b01) $display("FAIL enc_rsp_valid got=%b exp=01", bus.rsp_valid); else passed++;
        checks++; if (bus.rsp_data !== 32'hDEAD_BEEF) $display("FAIL enc_rsp_data got=%h exp=deadbeef", bus.rsp_data); else passed++;
        checks++; if (bus.rsp_err !== 1'b0) $display("FAIL enc_rsp_err got=%b exp=0", bus.rsp_err); else passed++;
        bus.rsp_ready = 2'b01;
        @(negedge clk); #1;
        bus.rsp_ready = 2'b00;
        checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL enc_rsp_consumed got=%b exp=00", bus.rsp_valid); else passed++;
        checks++; if (enc_cnt - e0 != 1 || dec_cnt - d0 != 0) $display("FAIL enc_strobe_count got=%0d/%0d exp=1/0", enc_cnt - e0, dec_cnt - d0); else passed++;
    endtask

    task automatic test_illegal_rounds();
        int t0, e0, d0;
        e0 = enc_cnt; d0 = dec_cnt;
        @(negedge clk);
        bus.req_op[1] = 1'b0; bus.req_rounds[1] = 5'd0; bus.req_data[1] = 32'h5555_AAAA;
        bus.req_valid[1] = 1'b1;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.req_ready[1]) begin t0 = cyc; break; end
            @(negedge clk);
        end
        checks++; if (t0 < 0 || bus.req_ready !== 2'b10) $display("FAIL ill_accept got=%b exp=10", bus.req_ready); else passed++;
        @(negedge clk); #1;
        bus.req_valid[1] = 1'b0;
        checks++; if (bus.rsp_valid !== 2'b10) $display("FAIL ill_rsp_valid got=%b exp=10", bus.rsp_valid); else passed++;
        checks++; if (bus.rsp_err !== 1'b1) $display("FAIL ill_rsp_err got=%b exp=1", bus.rsp_err); else passed++;
        checks++; if (bus.rsp_data !== 32'h0) $display("FAIL ill_rsp_data got=%h exp=0", bus.rsp_data); else passed++;
        bus.rsp_ready = 2'b10;
        @(negedge clk); #1;
        bus.rsp_ready = 2'b00;
        checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL ill_rsp_consumed got=%b exp=00", bus.rsp_valid); else passed++;
        checks++; if ((enc_cnt - e0) + (dec_cnt - d0) != 0) $display("FAIL ill_no_strobe got=%0d exp=0", (enc_cnt - e0) + (dec_cnt - d0)); else passed++;
    endtask

    task automatic test_timeout();
        int t0, r;
        cm_hang = 1'b1;
        @(negedge clk);
        bus.req_op[0] = 1'b0; bus.req_rounds[0] = 5'd5; bus.req_data[0] = 32'h1111_2222;
        bus.req_valid[0] = 1'b1;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.req_ready[0]) begin t0 = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        r = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != 2'b00) begin r = cyc; break; end
        end
        checks++; if (t0 < 0 || r != t0 + 18) $display("FAIL to_rsp_cycle got=%0d exp=%0d", r, t0 + 18); else passed++;
        checks++; if (bus.rsp_err !== 1'b1) $display("FAIL to_rsp_err got=%b exp=1", bus.rsp_err); else passed++;
        checks++; if (bus.rsp_data !== 32'h0) $display("FAIL to_rsp_data got=%h exp=0", bus.rsp_data); else passed++;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        cm_hang = 1'b0; cm_delay = 3; cm_result = 32'h1234_5678;
        bus.req_data[0]  = 32'h3333_4444;
        bus.req_valid[0] = 1'b1;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.req_ready[0]) begin t0 = cyc; break; end
            @(negedge clk);
        end
        checks++; if (t0 < 0) $display("FAIL to_next_accept got=none exp=req0"); else passed++;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        r = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != 2'b00) begin r = cyc; break; end
        end
        checks++; if (r != t0 + 5) $display("FAIL to_next_cycle got=%0d exp=%0d", r, t0 + 5); else passed++;
        checks++; if (bus.rsp_data !== 32'h1234_5678 || bus.rsp_err !== 1'b0) $display("FAIL to_next_rsp got=%h/%b exp=12345678/0", bus.rsp_data, bus.rsp_err); else passed++;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_hold_decrypt();
        int t0, r, n0, h0, bad;
        logic [127:0] k1;
        k1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        h0 = hs_cnt;
        cm_delay = 4; cm_result = 32'hCAFE_F00D;
        @(negedge clk);
        bus.req_op[1] = 1'b1; bus.req_rounds[1] = 5'd20; bus.req_key[1] = k1; bus.req_data[1] = 32'h9999_0000;
        bus.req_valid[1] = 1'b1;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.req_ready[1]) begin t0 = cyc; break; end
            @(negedge clk);
        end
        checks++; if (t0 < 0) $display("FAIL dec_accept got=none exp=req1"); else passed++;
        @(negedge clk); #1;
        bus.req_valid[1] = 1'b0;
        checks++; if (core_decrypt !== 1'b1 || core_encrypt !== 1'b0) $display("FAIL dec_strobe got=%b%b exp=01", core_encrypt, core_decrypt); else passed++;
        checks++; if (core_key !== k1) $display("FAIL dec_key got=%h exp=%h", core_key, k1); else passed++;
        bus.req_op[0] = 1'b0; bus.req_rounds[0] = 5'd3; bus.req_data[0] = 32'h4444_0000;
        bus.req_valid[0] = 1'b1;
        bus.rsp_ready    = 2'b01;
        r = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != 2'b00) begin r = cyc; break; end
        end
        checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'hCAFE_F00D || bus.rsp_err !== 1'b0) $display("FAIL dec_rsp got=%b/%h/%b exp=10/cafef00d/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); else passed++;
        n0 = acc_idx.size();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'hCAFE_F00D || bus.rsp_err !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad); else passed++;
        checks++; if (acc_idx.size() != n0) $display("FAIL hold_no_accept got=%0d exp=0", acc_idx.size() - n0); else passed++;
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        bus.rsp_ready = 2'b01;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.req_ready[0]) begin t0 = cyc; break; end
            @(negedge clk);
        end
        checks++; if (t0 < 0) $display("FAIL hold_next_accept got=none exp=req0"); else passed++;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        bus.rsp_ready = 2'b00;
        checks++; if (hs_cnt - h0 != 2) $display("FAIL hold_responses got=%0d exp=2", hs_cnt - h0); else passed++;
    endtask

    task automatic test_reset_mid_job();
        int t0, r;
        cm_hang = 1'b1;
        @(negedge clk);
        bus.req_op[0] = 1'b0; bus.req_rounds[0] = 5'd9; bus.req_key[0] = {4{32'h7777_7777}}; bus.req_data[0] = 32'h7777_0001;
        bus.req_valid[0] = 1'b1;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.req_ready[0]) begin t0 = cyc; break; end
            @(negedge clk);
        end
        checks++; if (t0 < 0) $display("FAIL mid_accept got=none exp=req0"); else passed++;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_rounds[1] = 5'd4;
        #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) $display("FAIL mid_rst_handshake got=%b/%b exp=00/00", bus.req_ready, bus.rsp_valid); else passed++;
        checks++; if (core_encrypt !== 1'b0 || core_decrypt !== 1'b0) $display("FAIL mid_rst_strobes got=%b%b exp=00", core_encrypt, core_decrypt); else passed++;
        checks++; if (bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) $display("FAIL mid_rst_rsp got=%h/%b exp=0/0", bus.rsp_data, bus.rsp_err); else passed++;
        checks++; if (core_num_rounds !== 5'd0 || core_key !== 128'h0 || core_d_in !== 32'h0) $display("FAIL mid_rst_operands got=%0d/%h/%h exp=0", core_num_rounds, core_key, core_d_in); else passed++;
        repeat (2) @(negedge clk);
        cm_hang = 1'b0; cm_delay = 2; cm_result = 32'h600D_0001;
        bus.req_data[0] = 32'h0000_0042;
        rst = 1'b1;
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (|bus.req_ready) begin t0 = cyc; break; end
            @(negedge clk);
        end
        checks++; if (t0 < 0 || bus.req_ready !== 2'b01) $display("FAIL mid_first_grant got=%b exp=01", bus.req_ready); else passed++;
        @(negedge clk);
        bus.req_valid = 2'b00;
        r = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid != 2'b00) begin r = cyc; break; end
        end
        checks++; if (r != t0 + 4 || bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'h600D_0001) $display("FAIL mid_new_rsp got=%0d/%b/%h exp=%0d/01/600d0001", r, bus.rsp_valid, bus.rsp_data, t0 + 4); else passed++;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        checks++; if (both_cnt != 0) $display("FAIL both_strobes got=%0d exp=0", both_cnt); else passed++;
    endtask

    initial begin
        rst = 1'b0;
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_rounds = '0;
        bus.req_key    = '0;
        bus.req_data   = '0;
        bus.rsp_ready  = '0;
        test_reset();
        test_round_robin();
        test_single_encrypt();
        test_illegal_rounds();
        test_timeout();
        test_hold_decrypt();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end
endmodule

// File: doc/rc5_core_sched.md
# rc5_core_sched

Request scheduler in front of the `algo` RC5 core. It accepts encrypt/decrypt jobs from `N_REQ` independent requesters over valid/ready handshakes and grants the single core to one job at a time in round-robin order. It sequences the core's one-cycle start strobe, waits for `done` under a watchdog, and returns the result to the owning requester. It sits between the system-side job sources and the core; the core is never driven directly by requesters.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 1023: maximum WAIT cycles before a job is aborted with error.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  job offered by requester i.
- `req_ready`  out  N_REQ  job accepted from requester i this cycle.
- `req_op`  in  N_REQ  0 = encrypt, 1 = decrypt.
- `req_rounds`  in  N_REQ x 5  round count, 1-based; 0 is illegal.
- `req_key`  in  N_REQ x 128  key.
- `req_data`  in  N_REQ x 32  input block.
- `rsp_valid`  out  N_REQ  result pending for requester i.
- `rsp_ready`  in  N_REQ  requester i consumes the result.
- `rsp_data`  out  32  result word, shared; meaningful only where `rsp_valid` is set.
- `rsp_err`  out  1  qualifies `rsp_data`: 1 = illegal rounds or timeout.
- `core_encrypt`, `core_decrypt`  out  1 each  start strobes to the core.
- `core_num_rounds`  out  5;  `core_key`  out  128;  `core_d_in`  out  32.
- `core_d_out`  in  32;  `core_done`  in  1.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: round-robin arbiter picks the lowest index at or above `rr_ptr` with `req_valid` set, wrapping. `req_ready[g]` is asserted combinationally for the grant `g` only. On acceptance, latch op, rounds, key and data, and record `g`.
  - Rounds 0: skip to RESP with `rsp_err=1`, `rsp_data=0`.
  - Otherwise go to ISSUE.
- ISSUE, exactly one cycle: assert `core_encrypt` or `core_decrypt` per the latched op, never both. Then go to WAIT.
- `core_num_rounds`, `core_key` and `core_d_in` are driven from the latched values, stable from ISSUE until the next acceptance.
- WAIT: watchdog counter starts at 0 and increments each cycle.
  - `core_done=1`: capture `core_d_out` into `rsp_data`, set `rsp_err=0`, go to RESP.
  - Counter reaches `TIMEOUT` without `core_done`: `rsp_data=0`, `rsp_err=1`, go to RESP.
- RESP: hold `rsp_valid[g]=1`, `rsp_data` and `rsp_err` stable until `rsp_ready[g]`. On the cycle `rsp_ready[g]` is seen, set `rr_ptr = (g+1) mod N_REQ` and go to IDLE.
- Other requesters' `rsp_ready` is ignored. `core_done` is ignored outside WAIT.
- At most one job is in flight; `req_ready` is 0 in every state except IDLE.

## Timing
- Reset (async assert, sync deassert internally):
  - state IDLE; `rr_ptr=0`.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, both strobes, `core_num_rounds`, `core_key`, `core_d_in`.
- Cycle sequence for a legal job:
  - Accept at cycle T.
  - Strobe high at T+1.
  - WAIT from T+2.
  - `core_done` seen at cycle D gives `rsp_valid` at D+1.
- Illegal-rounds job: accepted at T, `rsp_valid` at T+1; no strobe is issued.
- Minimum spacing between acceptances is 4 cycles, with zero-cycle `rsp_ready`.
- `rsp_ready` held high before the response appears: response lasts exactly 1 cycle.
- Reset asserted mid-job: the job is dropped with no response, strobes fall immediately, and `rr_ptr` returns to 0. Core state is the core's own concern.
- A `req_valid` deasserting before acceptance is legal and is simply not granted.

## Structure
- `rc5_pkg` holds:
  - `RC5_WORD_W=32`, `RC5_KEY_W=128`, `RC5_ROUNDS_W=5`.
  - `rc5_op_e` {ENC, DEC}.
  - `sched_state_e`.
  - The job struct (op, rounds, key, data).
- Sub-module `rr_arbiter`, parameterised on `N_REQ`: inputs request vector and pointer; outputs one-hot grant and index. Purely combinational; the pointer register lives in the scheduler.
- Target size: roughly 200 lines.

## Test plan
- Single encrypt, req0 (rounds 12, key 0, data 0x0000_0000), core model returning 0xDEAD_BEEF after 13 cycles:
  - `core_encrypt` high exactly 1 cycle at T+1.
  - `rsp_valid[0]` at D+1 with `rsp_data=0xDEAD_BEEF`, `rsp_err=0`.
- Both requesters valid continuously, N_REQ=2:
  - Grants alternate 0,1,0,1 over 4 jobs.
  - `req_ready` never asserted outside IDLE.
- req1 with rounds 0: `rsp_valid[1]` at T+1 with `rsp_err=1`, `rsp_data=0`; no strobe observed.
- Core model never asserts `done`, TIMEOUT=15: `rsp_err=1` at the 16th WAIT cycle plus 1; the next job is then accepted normally.
- `rsp_ready` withheld 20 cycles with a decrypt result pending: `rsp_data` and `rsp_err` stable throughout; no new acceptance.
- `rst` pulled low during WAIT: all outputs 0 asynchronously; after release the first grant goes to req0 even when req1 was last served.
